redmule_job_sequencer: RTL and testbench

- Hardware job launcher for the RedMulE tile.
- Accepts a matrix-multiply job descriptor over a valid/ready port, acquires a RedMulE job slot through the HWPE control slave port, and writes the job registers. It then triggers execution, waits for the RedMulE end-of-job event and returns a completion record.
- Sits between the core-side job queue and the RedMulE control port, so the core no longer has to issue each register access itself.

---
 rtl/redmule_tile_pkg.sv | 13 +
 rtl/redmule_job_sequencer.sv | 102 ++++++++++
 tb/tb_redmule_job_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_tile_pkg.sv
// redmule_tile_pkg: shared RedMulE control-port offsets and job sequencer state encoding
package redmule_tile_pkg;

    localparam logic [31:0] REDMULE_TRIGGER_OFS  = 32'h00;
    localparam logic [31:0] REDMULE_ACQUIRE_OFS  = 32'h04;
    localparam logic [31:0] REDMULE_SOFTCLR_OFS  = 32'h14;
    localparam logic [31:0] REDMULE_JOB_BASE_OFS = 32'h40;

    typedef enum logic [2:0] {
        IDLE, ACQ, ACQ_RSP, BACKOFF, PROG, TRIG, WAIT_EVT, DONE
    } redmule_seq_state_e;

endpackage

// File: rtl/redmule_job_sequencer.sv
// redmule_job_sequencer: acquires a RedMulE slot, programs the job registers, triggers and reports completion
module redmule_job_sequencer
    import redmule_tile_pkg::*;
#(
    parameter int          AW         = 32,
    parameter int          DW         = 32,
    parameter int          IW         = 2,
    parameter int          N_JOB_REGS = 8,
    parameter logic [31:0] JOB_BASE   = REDMULE_JOB_BASE_OFS,
    parameter int          RETRY_WAIT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [N_JOB_REGS*DW-1:0] job_regs_i,
    output logic                     done_valid_o,
    input  logic                     done_ready_i,
    output logic [7:0]               done_id_o,
    output logic                     busy_o,
    output logic                     ctrl_req_o,
    input  logic                     ctrl_gnt_i,
    output logic [AW-1:0]            ctrl_add_o,
    output logic                     ctrl_wen_o,
    output logic [DW/8-1:0]          ctrl_be_o,
    output logic [DW-1:0]            ctrl_data_o,
    output logic [IW-1:0]            ctrl_id_o,
    input  logic                     ctrl_r_valid_i,
    input  logic [DW-1:0]            ctrl_r_data_i,
    input  logic                     evt_i
);

    localparam int IXW = N_JOB_REGS > 1 ? $clog2(N_JOB_REGS) : 1;
    localparam int CW  = $clog2(RETRY_WAIT + 2);
    localparam logic [IXW-1:0] LAST_IDX = IXW'(N_JOB_REGS - 1);

    redmule_seq_state_e                   state_q, state_d;
    logic [IXW-1:0]                       idx_q;
    logic [CW-1:0]                        cnt_q;
    logic [7:0]                           id_q;
    logic                                 busy_q;
    logic [N_JOB_REGS-1:0][DW-1:0]        desc_q;
    logic                                 unused_rdata;

    assign unused_rdata = ^ctrl_r_data_i;

    assign job_ready_o  = state_q == IDLE;
    assign done_valid_o = state_q == DONE;
    assign done_id_o    = id_q;
    assign busy_o       = busy_q;
    assign ctrl_req_o   = state_q inside {ACQ, PROG, TRIG};
    assign ctrl_wen_o   = state_q == ACQ;
    assign ctrl_be_o    = '1;
    assign ctrl_id_o    = '0;
    assign ctrl_add_o   = state_q == ACQ  ? AW'(REDMULE_ACQUIRE_OFS) :
                          state_q == PROG ? AW'(JOB_BASE) + AW'({idx_q, 2'b00}) :
                          state_q == TRIG ? AW'(REDMULE_TRIGGER_OFS) : '0;
    assign ctrl_data_o  = state_q == PROG ? desc_q[idx_q] : '0;

    // next-state logic; each control access advances only on its grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (job_valid_i) state_d = ACQ;
            ACQ:      if (ctrl_gnt_i) state_d = ACQ_RSP;
            ACQ_RSP:  if (ctrl_r_valid_i) state_d = ctrl_r_data_i[31] ? BACKOFF : PROG;
            BACKOFF:  if (cnt_q <= CW'(1)) state_d = ACQ;
            PROG:     if (ctrl_gnt_i && idx_q == LAST_IDX) state_d = TRIG;
            TRIG:     if (ctrl_gnt_i) state_d = WAIT_EVT;
            WAIT_EVT: if (evt_i) state_d = DONE;
            DONE:     if (done_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // state register, retry counter, register index and acquired job id
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            if (state_q == ACQ_RSP && ctrl_r_valid_i) begin
                cnt_q <= CW'(RETRY_WAIT);
                idx_q <= '0;
                if (!ctrl_r_data_i[31]) id_q <= ctrl_r_data_i[7:0];
            end
            if (state_q == BACKOFF) cnt_q <= cnt_q - 1'b1;
            if (state_q == PROG && ctrl_gnt_i && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
    end

    // descriptor buffer captured on acceptance; deliberately not reset
    always_ff @(posedge clk_i) begin
        if (job_valid_i && job_ready_o) desc_q <= job_regs_i;
    end

endmodule

// File: tb/tb_redmule_job_sequencer.sv
// tb_redmule_job_sequencer: randomized directed jobs checked against a transaction-level model
module tb_redmule_job_sequencer;
    import redmule_tile_pkg::*;

    localparam int AW = 32, DW = 32, IW = 2, N = 8, RW = 4;
    localparam logic [31:0] JB = 32'h40;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
    } tx_t;

    logic            clk_i = 1'b0;
    logic            rst_i, job_valid_i, job_ready_o, done_valid_o, done_ready_i, busy_o;
    logic [N*DW-1:0] job_regs_i;
    logic [7:0]      done_id_o;
    logic            ctrl_req_o, ctrl_gnt_i, ctrl_wen_o, ctrl_r_valid_i, evt_i;
    logic [AW-1:0]   ctrl_add_o;
    logic [DW/8-1:0] ctrl_be_o;
    logic [DW-1:0]   ctrl_data_o, ctrl_r_data_i;
    logic [IW-1:0]   ctrl_id_o;

    redmule_job_sequencer #(.AW(AW), .DW(DW), .IW(IW), .N_JOB_REGS(N), .JOB_BASE(JB), .RETRY_WAIT(RW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_regs_i(job_regs_i), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_id_o(done_id_o), .busy_o(busy_o), .ctrl_req_o(ctrl_req_o), .ctrl_gnt_i(ctrl_gnt_i),
        .ctrl_add_o(ctrl_add_o), .ctrl_wen_o(ctrl_wen_o), .ctrl_be_o(ctrl_be_o),
        .ctrl_data_o(ctrl_data_o), .ctrl_id_o(ctrl_id_o), .ctrl_r_valid_i(ctrl_r_valid_i),
        .ctrl_r_data_i(ctrl_r_data_i), .evt_i(evt_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0, n_err = 0, cyc = 0;
    tx_t         txq[$];
    logic [31:0] acq_rsp[$];
    logic [31:0] regs_m[N];
    logic [31:0] rsp_data, prev_add, prev_data;
    logic [7:0]  exp_id, prev_id;
    bit          fast = 1, rsp_active = 0, prev_stall = 0, prev_done_pend = 0, expect_done = 0;
    bit          evt_fired = 0, spur_idle = 0, spur_prog = 0, job_pending = 0, preload_next = 0, chk_b2b = 0;
    int          rsp_wait = 0, stall_reg = -1, stall_left = 0, evt_cnt = -1, evt_delay = 0;
    int          hold_left = 0, done_cnt = 0, last_done_cyc = 0, n_reads = 0, idle = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_regs(input bit pat);
        for (int i = 0; i < N; i++) begin
            regs_m[i] = pat ? 32'(i) * 32'h11 : $urandom;
            job_regs_i[i*DW +: DW] = regs_m[i];
        end
    endtask

    // one cycle: check outputs at the falling edge, then drive inputs for the next rising edge
    task automatic tick();
        logic gnt;
        @(negedge clk_i);
        cyc++;
        if (prev_stall) begin
            chk("stall_req", ctrl_req_o, 1);
            chk("stall_add", ctrl_add_o, prev_add);
            chk("stall_data", ctrl_data_o, prev_data);
        end
        if (prev_done_pend) begin
            chk("done_hold", done_valid_o, 1);
            chk("done_id_hold", done_id_o, prev_id);
        end
        if (expect_done) begin
            chk("done_after_evt", done_valid_o, 1);
            expect_done = 0;
        end
        if (done_valid_o && !prev_done_pend) begin
            chk("done_has_evt", evt_fired, 1);
            evt_fired = 0;
        end
        if (done_valid_o) begin
            chk("done_id", done_id_o, exp_id);
            chk("no_ready_in_done", job_ready_o, 0);
        end
        chk("busy_is_not_ready", busy_o, !job_ready_o);
        if (!job_pending) for (int i = 0; i < N; i++) job_regs_i[i*DW +: DW] = $urandom;
        if (preload_next && done_valid_o && !job_pending) begin
            load_regs(0);
            job_pending = 1;
            chk_b2b = 1;
            preload_next = 0;
        end
        job_valid_i = job_pending;
        if (job_pending && job_ready_o) begin
            job_pending = 0;
            if (chk_b2b) begin
                chk("accept_first_idle", cyc, last_done_cyc + 1);
                chk_b2b = 0;
            end
        end
        evt_i = 0;
        if (spur_idle) begin
            evt_i = 1;
            spur_idle = 0;
        end
        if (spur_prog && ctrl_req_o && !ctrl_wen_o && ctrl_add_o >= JB) begin
            evt_i = 1;
            spur_prog = 0;
        end
        if (evt_cnt == 0) begin
            evt_i = 1;
            evt_fired = 1;
            expect_done = 1;
            evt_cnt = -1;
        end else if (evt_cnt > 0) evt_cnt--;
        if (!ctrl_req_o) idle++;
        ctrl_r_valid_i = 0;
        ctrl_r_data_i = $urandom;
        if (rsp_active) begin
            if (rsp_wait == 0) begin
                ctrl_r_valid_i = 1;
                ctrl_r_data_i = rsp_data;
                rsp_active = 0;
                idle = 0;
            end else rsp_wait--;
        end
        if (ctrl_req_o && !ctrl_wen_o && ctrl_add_o == JB + 32'(4 * stall_reg) && stall_left > 0) begin
            gnt = 0;
            stall_left--;
        end else gnt = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        ctrl_gnt_i = gnt;
        prev_stall = ctrl_req_o && !gnt;
        prev_add = ctrl_add_o;
        prev_data = ctrl_data_o;
        if (ctrl_req_o && gnt) begin
            txq.push_back('{ctrl_wen_o, ctrl_add_o, ctrl_data_o});
            if (ctrl_wen_o) begin
                if (n_reads > 0) chk("retry_gap_ge_wait", idle >= RW, 1);
                n_reads++;
                rsp_data = acq_rsp.size() > 0 ? acq_rsp.pop_front() : 32'h8000_0000;
                rsp_active = 1;
                rsp_wait = fast ? 0 : int'($urandom_range(0, 2));
            end else if (ctrl_add_o == REDMULE_TRIGGER_OFS) evt_cnt = evt_delay;
        end
        if (done_valid_o) begin
            if (hold_left > 0) begin
                done_ready_i = 0;
                hold_left--;
            end else done_ready_i = 1;
        end else done_ready_i = 1'($urandom_range(0, 1));
        if (done_valid_o && done_ready_i) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        prev_done_pend = done_valid_o && !done_ready_i;
        prev_id = done_id_o;
    endtask

    // runs one job and compares the control traffic with the expected access sequence
    task automatic run_job(input int nbusy, input logic [31:0] acq_final, input bit pat, input int st_reg,
                           input int st_n, input int ev_d, input int hold, input bit spur, input bit fst,
                           input int rst_reg);
        logic [31:0] er[N];
        logic [31:0] ea, ed;
        logic        ew;
        int          nexp;
        txq.delete();
        acq_rsp.delete();
        done_cnt = 0;
        n_reads = 0;
        idle = 0;
        fast = fst;
        stall_reg = st_reg;
        stall_left = st_n;
        evt_delay = ev_d;
        hold_left = hold;
        spur_prog = spur;
        exp_id = acq_final[7:0];
        repeat (nbusy) acq_rsp.push_back(32'h8000_0000 | $urandom);
        acq_rsp.push_back(acq_final);
        if (!job_pending) begin
            load_regs(pat);
            job_pending = 1;
        end
        er = regs_m;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            tick();
            if (rst_reg >= 0 && txq.size() > 0 && !txq[txq.size()-1].wen &&
                txq[txq.size()-1].add == JB + 32'(4 * rst_reg)) begin
                rst_i = 1;
                tick();
                rst_i = 0;
                prev_stall = 0;
                prev_done_pend = 0;
                expect_done = 0;
                rsp_active = 0;
                evt_cnt = -1;
                spur_prog = 0;
                tick();
                chk("rst_req", ctrl_req_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_ready", job_ready_o, 1);
                chk("rst_done", done_valid_o, 0);
                chk("rst_id", done_id_o, 0);
                chk("rst_no_done", done_cnt, 0);
                return;
            end
        end
        chk("job_completes", done_cnt, 1);
        nexp = nbusy + N + 2;
        chk("tx_count", txq.size(), nexp);
        for (int k = 0; k < txq.size() && k < nexp; k++) begin
            ew = k <= nbusy;
            ea = ew ? REDMULE_ACQUIRE_OFS : k == nexp - 1 ? REDMULE_TRIGGER_OFS : JB + 32'(4 * (k - nbusy - 1));
            ed = (ew || k == nexp - 1) ? 32'h0 : er[k - nbusy - 1];
            chk("tx_wen", txq[k].wen, ew);
            chk("tx_add", txq[k].add, ea);
            if (!ew) chk("tx_data", txq[k].data, ed);
        end
        if (!job_pending) begin
            repeat (4) tick();
            chk("done_once", done_cnt, 1);
        end
    endtask

    initial begin
        rst_i = 1;
        job_valid_i = 0;
        job_regs_i = '0;
        done_ready_i = 0;
        ctrl_gnt_i = 0;
        ctrl_r_valid_i = 0;
        ctrl_r_data_i = '0;
        evt_i = 0;
        tick();
        tick();
        chk("reset_ready", job_ready_o, 1);
        chk("reset_done_valid", done_valid_o, 0);
        chk("reset_req", ctrl_req_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_add", ctrl_add_o, 0);
        chk("reset_data", ctrl_data_o, 0);
        chk("reset_done_id", done_id_o, 0);
        chk("be_all_ones", ctrl_be_o, 4'hf);
        chk("txn_id_zero", ctrl_id_o, 0);
        rst_i = 0;
        spur_idle = 1;
        repeat (3) tick();
        chk("spur_idle_no_done", done_cnt, 0);
        chk("spur_idle_not_busy", busy_o, 0);
        run_job(0, 32'h0000_0003, 1, -1, 0, 4, 0, 0, 1, -1);
        run_job(2, 32'h0000_0001, 0, -1, 0, 3, 0, 0, 1, -1);
        run_job(0, $urandom & 32'h7fff_ffff, 0, 2, 3, 2, 0, 0, 1, -1);
        preload_next = 1;
        run_job(0, $urandom & 32'h7fff_ffff, 0, -1, 0, 3, 10, 0, 1, -1);
        run_job(0, $urandom & 32'h7fff_ffff, 0, -1, 0, 2, 0, 0, 1, -1);
        run_job(0, $urandom & 32'h7fff_ffff, 0, -1, 0, 3, 0, 0, 1, 4);
        run_job(1, $urandom & 32'h7fff_ffff, 0, -1, 0, 3, 0, 0, 1, -1);
        run_job(0, $urandom & 32'h7fff_ffff, 0, -1, 0, 6, 0, 1, 1, -1);
        repeat (8) run_job(int'($urandom_range(0, 2)), $urandom & 32'h7fff_ffff, 0,
                           int'($urandom_range(0, 8)) - 1, int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                           1'($urandom_range(0, 1)), 0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
